// File: rtl/johnson_dec_mon.sv
// Johnson-code decoder and step-order monitor: decodes an N-bit Johnson word, tracks lock/error/resync.
// Optional wrap counter enabled by defining JDEC_WRAP_CNT_EN; otherwise wrap_cnt is tied to zero.
module johnson_dec_mon #(
    parameter int N      = 4,
    parameter int RESYNC = 3,
    parameter int WCW    = 8
) (
    input  logic                     ck,
    input  logic                     clr,
    input  logic                     en,
    input  logic [N-1:0]             code,
    output logic [$clog2(2*N)-1:0]   idx,
    output logic [2*N-1:0]           onehot,
    output logic                     valid,
    output logic                     illegal,
    output logic                     seq_err,
    output logic                     locked,
    output logic                     wrap,
    output logic [WCW-1:0]           wrap_cnt
);

    localparam int IW = $clog2(2*N);
    localparam int CW = $clog2(RESYNC+1);
    localparam logic [IW-1:0] IDX_LAST = IW'(2*N-1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRACK = 2'd1,
        ST_ERR   = 2'd2
    } state_t;

    // Fold an msb=1 word onto its complement so both halves reduce to "ones contiguous from bit0".
    function automatic logic is_legal_f(input logic [N-1:0] c);
        logic [N-1:0] t;
        t = c[N-1] ? ~c : c;
        return ((t & (t + {{(N-1){1'b0}}, 1'b1})) == {N{1'b0}});
    endfunction

    function automatic logic [IW-1:0] decode_f(input logic [N-1:0] c);
        int pc;
        pc = 0;
        for (int i = 0; i < N; i++) begin
            if (c[i]) pc++;
        end
        return c[N-1] ? IW'(2*N - pc) : IW'(pc);
    endfunction

    state_t          state_r, state_s;
    logic [IW-1:0]   idx_r, idx_s, new_idx_s, inc_idx_s;
    logic [2*N-1:0]  onehot_r, onehot_s;
    logic [CW-1:0]   cnt_r, cnt_s;
    logic            valid_r, valid_s;
    logic            illegal_r, illegal_s;
    logic            seq_err_r, seq_err_s;
    logic            locked_r, locked_s;
    logic            wrap_r, wrap_s;
    logic            legal_s, hold_s, step_s;

    // Decode the sampled word and classify it against the previous index.
    always_comb begin
        legal_s   = is_legal_f(code);
        new_idx_s = decode_f(code);
        inc_idx_s = (idx_r == IDX_LAST) ? {IW{1'b0}} : idx_r + IW'(1);
        hold_s    = (new_idx_s == idx_r);
        step_s    = (new_idx_s == inc_idx_s);
    end

    // Next-state and next-output logic for the IDLE/TRACK/ERR monitor.
    always_comb begin
        state_s   = state_r;
        idx_s     = idx_r;
        valid_s   = valid_r;
        cnt_s     = cnt_r;
        illegal_s = 1'b0;
        seq_err_s = 1'b0;
        wrap_s    = 1'b0;
        if (en) begin
            if (!legal_s) begin
                illegal_s = 1'b1;
                if (state_r == ST_TRACK) begin
                    state_s = ST_ERR;
                    cnt_s   = {CW{1'b0}};
                end else if (state_r == ST_ERR) begin
                    cnt_s   = {CW{1'b0}};
                end else begin
                    state_s = state_r;
                end
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        idx_s   = new_idx_s;
                        valid_s = 1'b1;
                        cnt_s   = {CW{1'b0}};
                        state_s = ST_TRACK;
                    end
                    ST_TRACK: begin
                        idx_s = new_idx_s;
                        if (hold_s || step_s) begin
                            wrap_s = step_s && (idx_r == IDX_LAST);
                        end else begin
                            seq_err_s = 1'b1;
                            cnt_s     = {CW{1'b0}};
                            state_s   = ST_ERR;
                        end
                    end
                    ST_ERR: begin
                        idx_s = new_idx_s;
                        if (hold_s) begin
                            cnt_s = cnt_r;
                        end else if (step_s) begin
                            // Count reaching RESYNC re-locks; the counter restarts for the next loss.
                            if (cnt_r + CW'(1) == CW'(RESYNC)) begin
                                cnt_s   = {CW{1'b0}};
                                state_s = ST_TRACK;
                            end else begin
                                cnt_s = cnt_r + CW'(1);
                            end
                        end else begin
                            seq_err_s = 1'b1;
                            cnt_s     = {CW{1'b0}};
                        end
                    end
                    default: begin
                        state_s = ST_IDLE;
                        valid_s = 1'b0;
                        cnt_s   = {CW{1'b0}};
                    end
                endcase
            end
        end else begin
            state_s = state_r;
        end
        locked_s = (state_s == ST_TRACK);
        for (int i = 0; i < 2*N; i++) begin
            onehot_s[i] = valid_s && (idx_s == IW'(i));
        end
    end

    // State and output registers.
    always_ff @(posedge ck or negedge clr) begin
        if (!clr) begin
            state_r   <= ST_IDLE;
            idx_r     <= {IW{1'b0}};
            onehot_r  <= {(2*N){1'b0}};
            cnt_r     <= {CW{1'b0}};
            valid_r   <= 1'b0;
            illegal_r <= 1'b0;
            seq_err_r <= 1'b0;
            locked_r  <= 1'b0;
            wrap_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            idx_r     <= idx_s;
            onehot_r  <= onehot_s;
            cnt_r     <= cnt_s;
            valid_r   <= valid_s;
            illegal_r <= illegal_s;
            seq_err_r <= seq_err_s;
            locked_r  <= locked_s;
            wrap_r    <= wrap_s;
        end
    end

`ifdef JDEC_WRAP_CNT_EN
    logic [WCW-1:0] wrap_cnt_r;

    // Free-running wrap counter; rolls over modulo 2^WCW.
    always_ff @(posedge ck or negedge clr) begin
        if (!clr) begin
            wrap_cnt_r <= {WCW{1'b0}};
        end else if (wrap_s) begin
            wrap_cnt_r <= wrap_cnt_r + WCW'(1);
        end else begin
            wrap_cnt_r <= wrap_cnt_r;
        end
    end

    assign wrap_cnt = wrap_cnt_r;
`else
    assign wrap_cnt = {WCW{1'b0}};
`endif

    assign idx     = idx_r;
    assign onehot  = onehot_r;
    assign valid   = valid_r;
    assign illegal = illegal_r;
    assign seq_err = seq_err_r;
    assign locked  = locked_r;
    assign wrap    = wrap_r;

endmodule

// File: tb/tb_johnson_dec_mon.sv
// Directed self-checking bench for johnson_dec_mon (N=4, RESYNC=3, WCW=8).
// Expected wrap_cnt depends on whether JDEC_WRAP_CNT_EN is defined for the build.
module tb_johnson_dec_mon;

    logic       ck = 1'b0;
    logic       clr;
    logic       en;
    logic [3:0] code;
    logic [2:0] idx;
    logic [7:0] onehot;
    logic       valid, illegal, seq_err, locked, wrap;
    logic [7:0] wrap_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    int n_wraps;

    johnson_dec_mon #(.N(4), .RESYNC(3), .WCW(8)) dut (
        .ck(ck), .clr(clr), .en(en), .code(code),
        .idx(idx), .onehot(onehot), .valid(valid), .illegal(illegal),
        .seq_err(seq_err), .locked(locked), .wrap(wrap), .wrap_cnt(wrap_cnt)
    );

    always #5 ck = ~ck;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference Johnson word for index i (0..7), written out by hand.
    function automatic logic [3:0] jc(input int i);
        logic [3:0] tbl [8];
        tbl = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000};
        return tbl[i % 8];
    endfunction

    task automatic drive(input logic e, input logic [3:0] c);
        @(negedge ck);
        en   = e;
        code = c;
        @(posedge ck);
        #1;
    endtask

    task automatic chk_all(input string tag, input int ei, input logic ev, input logic eill,
                           input logic eseq, input logic elock, input logic ewrap);
        logic [7:0] eoh;
        eoh = ev ? (8'b0000_0001 << ei) : 8'b0000_0000;
        chk({tag, ".idx"},     {29'd0, idx}, ei);
        chk({tag, ".onehot"},  {24'd0, onehot}, {24'd0, eoh});
        chk({tag, ".valid"},   {31'd0, valid}, {31'd0, ev});
        chk({tag, ".illegal"}, {31'd0, illegal}, {31'd0, eill});
        chk({tag, ".seq_err"}, {31'd0, seq_err}, {31'd0, eseq});
        chk({tag, ".locked"},  {31'd0, locked}, {31'd0, elock});
        chk({tag, ".wrap"},    {31'd0, wrap}, {31'd0, ewrap});
    endtask

    task automatic do_reset();
        @(negedge ck);
        clr  = 1'b0;
        en   = 1'b0;
        code = 4'b0000;
        @(negedge ck);
        clr  = 1'b1;
    endtask

    initial begin
        clr  = 1'b0;
        en   = 1'b0;
        code = 4'b0000;
        repeat (2) @(posedge ck);
        #1;
        chk_all("rst", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst.wrap_cnt", {24'd0, wrap_cnt}, 32'd0);
        @(negedge ck);
        clr = 1'b1;

        // 1: full sequence and back to 0
        for (int i = 0; i <= 8; i++) begin
            drive(1'b1, jc(i));
            chk_all($sformatf("t1.s%0d", i), i % 8, 1'b1, 1'b0, 1'b0, 1'b1, (i == 8));
        end

        // 2: illegal word while tracking at idx 2
        drive(1'b1, jc(1));
        drive(1'b1, jc(2));
        chk_all("t2.pre", 2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 4'b0101);
        chk_all("t2.ill", 2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 4'b0101);
        chk_all("t2.drop", 2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // 3: skip from idx 1 to 3, then resync after three +1 steps
        do_reset();
        drive(1'b1, jc(0));
        drive(1'b1, jc(1));
        drive(1'b1, jc(3));
        chk_all("t3.skip", 3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b1, jc(4));
        chk_all("t3.g1", 4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, jc(5));
        chk_all("t3.g2", 5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, jc(6));
        chk_all("t3.g3", 6, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

        // 4: bad step in ERR after two good steps restarts the count; holds don't count
        drive(1'b1, jc(0));
        chk_all("t4.err", 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b1, jc(1));
        drive(1'b1, jc(1));
        chk_all("t4.hold", 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, jc(2));
        chk_all("t4.g2", 2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, jc(0));
        chk_all("t4.skip", 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b1, jc(1));
        drive(1'b1, jc(2));
        chk_all("t4.r2", 2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, jc(3));
        chk_all("t4.r3", 3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

        // 5: en=0 holds everything, then async clear mid-stream
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, 4'($urandom_range(0, 15)));
            chk_all($sformatf("t5.hold%0d", k), 3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        drive(1'b1, 4'b1010);
        chk_all("t5.ill", 3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        clr = 1'b0;
        #2;
        chk_all("t5.aclr", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge ck);
        clr = 1'b1;

        // 6: 257 full cycles for the wrap counter
        do_reset();
        drive(1'b1, jc(0));
        n_wraps = 0;
        for (int c = 0; c < 257; c++) begin
            for (int j = 1; j <= 8; j++) begin
                drive(1'b1, jc(j));
                if (wrap === 1'b1) n_wraps++;
            end
        end
        chk("t6.wraps", n_wraps, 32'd257);
        chk("t6.locked", {31'd0, locked}, 32'd1);
`ifdef JDEC_WRAP_CNT_EN
        chk("t6.wrap_cnt", {24'd0, wrap_cnt}, 32'd1);
`else
        chk("t6.wrap_cnt", {24'd0, wrap_cnt}, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
